// File: rtl/thermo_ramp_gen.sv
// thermo_ramp_gen: multi-channel thermometer-code generator; levels jump or ramp one step per cycle.
module thermo_ramp_gen #(
    parameter int N  = 8,
    parameter int CH = 2,
    parameter int LW = $clog2(N + 1),
    parameter int CW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW-1:0]   in_ch,
    input  logic [LW-1:0]   in_level,
    input  logic            in_ramp,
    output logic [CH*N-1:0] therm_o,
    output logic [CH-1:0]   busy_o,
    output logic [CH-1:0]   done_o
);
    typedef enum logic {IDLE, RAMP} state_t;

    state_t        st [CH];
    state_t        st_n [CH];
    logic [LW-1:0] cur [CH];
    logic [LW-1:0] cur_n [CH];
    logic [LW-1:0] tgt [CH];
    logic [LW-1:0] tgt_n [CH];
    logic [CH-1:0]   done_n;
    logic [CH*N-1:0] therm_n;
    logic [LW-1:0]   t_lvl;
    logic            sel_busy;
    logic            acc;

    // Out-of-range channels never match, so they read as idle and the command is dropped.
    always_comb begin
        sel_busy = 1'b0;
        for (int c = 0; c < CH; c++)
            if (in_ch == CW'(c)) sel_busy = (st[c] == RAMP);
    end

    assign in_ready = !rst && !sel_busy;
    assign acc      = in_valid && in_ready;
    assign t_lvl    = (in_level > LW'(N)) ? LW'(N) : in_level;

    always_comb begin
        therm_n = '0;
        for (int c = 0; c < CH; c++) begin
            st_n[c]   = st[c];
            cur_n[c]  = cur[c];
            tgt_n[c]  = tgt[c];
            done_n[c] = 1'b0;
            busy_o[c] = (st[c] == RAMP);
            if (st[c] == RAMP) begin
                cur_n[c] = (cur[c] < tgt[c]) ? cur[c] + LW'(1) : cur[c] - LW'(1);
                if (cur_n[c] == tgt[c]) begin
                    st_n[c]   = IDLE;
                    done_n[c] = 1'b1;
                end
            end else if (acc && in_ch == CW'(c)) begin
                if (in_ramp && t_lvl != cur[c]) begin
                    st_n[c]  = RAMP;
                    tgt_n[c] = t_lvl;
                end else begin
                    cur_n[c]  = t_lvl;
                    done_n[c] = 1'b1;
                end
            end
            for (int i = 0; i < N; i++)
                therm_n[c*N + i] = (i >= int'(cur_n[c]));
        end
    end

    // therm_o is registered from the next level so it always tracks cur.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                st[c]  <= IDLE;
                cur[c] <= LW'(N);
                tgt[c] <= LW'(N);
            end
            done_o  <= '0;
            therm_o <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                st[c]  <= st_n[c];
                cur[c] <= cur_n[c];
                tgt[c] <= tgt_n[c];
            end
            done_o  <= done_n;
            therm_o <= therm_n;
        end
    end
endmodule

// File: tb/tb_thermo_ramp_gen.sv
// tb_thermo_ramp_gen: randomized scoreboard bench for thermo_ramp_gen against a level-trajectory model.
module tb_thermo_ramp_gen;
    localparam int N  = 8;
    localparam int CH = 2;
    localparam int LW = 4;
    localparam int CW = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ramp = 1'b0;
    logic [CW-1:0]   in_ch = '0;
    logic [LW-1:0]   in_level = '0;
    logic            in_ready;
    logic [CH*N-1:0] therm_o;
    logic [CH-1:0]   busy_o;
    logic [CH-1:0]   done_o;

    typedef struct {
        int         cy;
        logic [N-1:0] th;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t         q [CH][$];
    int           lvl [CH];
    logic [N-1:0] hold [CH];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    thermo_ramp_gen #(.N(N), .CH(CH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_level(in_level), .in_ramp(in_ramp),
        .therm_o(therm_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] th_of(input int l);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (i >= l);
        return r;
    endfunction

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic logic busy_m(input int c);
        return q[c].size() > 0 && q[c][0].busy;
    endfunction

    // Monitor: every cycle, compare each channel against its scheduled expectation or its held level.
    initial forever begin
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            exp_t e;
            if (q[c].size() > 0 && q[c][0].cy == cyc) begin
                e = q[c].pop_front();
                hold[c] = e.th;
            end else begin
                e.cy = cyc; e.th = hold[c]; e.busy = 1'b0; e.done = 1'b0;
            end
            check($sformatf("therm ch%0d cyc%0d", c, cyc), 32'(therm_o[c*N +: N]), 32'(e.th));
            check($sformatf("busy ch%0d cyc%0d", c, cyc), 32'(busy_o[c]), 32'(e.busy));
            check($sformatf("done ch%0d cyc%0d", c, cyc), 32'(done_o[c]), 32'(e.done));
            if (rst) begin
                q[c].delete();
                hold[c] = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic v, input int ch, input int l, input logic r);
        int t, d, dir;
        logic rdy;
        in_valid = v; in_ch = CW'(ch); in_level = LW'(l); in_ramp = r;
        #1;
        rdy = !rst && (ch >= CH || !busy_m(ch));
        check($sformatf("in_ready ch%0d cyc%0d", ch, cyc), 32'(in_ready), 32'(rdy));
        if (v && rdy && ch < CH) begin
            t = (l > N) ? N : l;
            if (r && t != lvl[ch]) begin
                d   = (t > lvl[ch]) ? t - lvl[ch] : lvl[ch] - t;
                dir = (t > lvl[ch]) ? 1 : -1;
                q[ch].push_back(exp_t'{cyc + 1, th_of(lvl[ch]), 1'b1, 1'b0});
                for (int j = 1; j <= d; j++)
                    q[ch].push_back(exp_t'{cyc + 1 + j, th_of(lvl[ch] + dir * j), j != d, j == d});
            end else
                q[ch].push_back(exp_t'{cyc + 1, th_of(t), 1'b0, 1'b1});
            lvl[ch] = t;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_rst(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < CH; c++) lvl[c] = N;
        repeat (n) begin
            #1;
            check($sformatf("in_ready rst cyc%0d", cyc), 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            lvl[c] = N;
            hold[c] = '0;
        end
        tick();
        do_rst(3);
        cmd(1, 0, 3, 0); tick();
        cmd(1, 0, 0, 0); tick();
        cmd(1, 1, 2, 1);
        cmd(1, 1, 5, 0);
        cmd(0, 1, 0, 0);
        repeat (6) tick();
        cmd(1, 0, 8, 0);
        cmd(1, 0, 0, 1);
        cmd(1, 1, 15, 0);
        repeat (9) tick();
        cmd(1, 0, 4, 0); tick();
        cmd(1, 0, 4, 1); tick(); tick();
        cmd(1, 1, 0, 1); tick(); tick();
        do_rst(1);
        tick();
        repeat (400) begin
            if ($urandom_range(0, 49) == 0)
                do_rst(int'($urandom_range(1, 2)));
            else
                cmd($urandom_range(0, 3) != 0, int'($urandom_range(0, CH - 1)),
                    int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        repeat (20) tick();
        for (int c = 0; c < CH; c++)
            check($sformatf("drain ch%0d", c), 32'(q[c].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
